cp0_exception_ctrl: RTL and testbench

- Coprocessor-0 register file and exception/interrupt sequencer, attached at the M stage.
- Decides when the fetch unit must redirect to the handler at 0x0000_4180 (`req`) and supplies the return address (`epc_out`) used on `eret`.
- Owns SR, Cause, EPC and PRId.
- Serves mfc0 reads and mtc0 writes from the pipeline.

---
 rtl/cp0_exception_ctrl_if.sv | 25 ++
 rtl/cp0_exception_ctrl.sv | 71 +++++++
 tb/tb_cp0_exception_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exception_ctrl_if.sv
// Pipeline-to-CP0 signal bundle: mfc0/mtc0 access, M-stage exception inputs,
// and the redirect request / return address going back to fetch.
interface cp0_exception_ctrl_if;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output addr, we, din, vpc, bd_in, exc_code_in, hw_int, eret,
        input  dout, req, epc_out
    );

    modport slave (
        input  addr, we, din, vpc, bd_in, exc_code_in, hw_int, eret,
        output dout, req, epc_out
    );
endinterface

// File: rtl/cp0_exception_ctrl.sv
// CP0 register file (SR, Cause, EPC, PRId) and exception/interrupt sequencer
// attached at the M stage; raises req when fetch must redirect to the handler.
module cp0_exception_ctrl #(
    parameter logic [31:0] PRID     = 32'h4B46_0001,
    parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
    input logic              clk,
    input logic              reset,
    cp0_exception_ctrl_if.slave bus
);
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;

    logic [31:0] sr;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        take;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] rd_data;

    // EXL blocks every request source; interrupts still show up in Cause.IP.
    assign int_req = (|(bus.hw_int & sr[15:10])) & sr[0] & ~sr[1];
    assign exc_req = (bus.exc_code_in != 5'd0) & ~sr[1];
    assign take    = (int_req | exc_req) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr        <= SR_RESET & SR_MASK;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= bus.hw_int;
            if (take) begin
                sr[1]     <= 1'b1;
                cause_exc <= int_req ? 5'd0 : bus.exc_code_in;
                cause_bd  <= bus.bd_in;
                epc       <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
            end else begin
                if (bus.we && bus.addr == 5'd12) sr  <= bus.din & SR_MASK;
                if (bus.we && bus.addr == 5'd14) epc <= bus.din;
                // Placed after the SR write so eret decides the final EXL value.
                if (bus.eret) sr[1] <= 1'b0;
            end
        end
    end

    assign sr_word    = sr;
    assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

    always_comb begin
        rd_data = 32'd0;
        case (bus.addr)
            5'd12:   rd_data = sr_word;
            5'd13:   rd_data = cause_word;
            5'd14:   rd_data = epc;
            5'd15:   rd_data = PRID;
            default: rd_data = 32'd0;
        endcase
    end

    assign bus.dout    = rd_data;
    assign bus.req     = take;
    assign bus.epc_out = reset ? 32'd0 : epc;
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Bench for cp0_exception_ctrl: directed scenarios plus randomized cycles
// compared against a word-level model of the CP0 registers.
module tb_cp0_exception_ctrl;
    localparam logic [31:0] PRID     = 32'h4B46_0001;
    localparam logic [31:0] SR_RESET = 32'h0000_0000;
    localparam logic [31:0] SR_MASK  = 32'h0000_FC03;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] m_sr    = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic [31:0] m_epc   = 32'd0;

    cp0_exception_ctrl_if bus ();

    cp0_exception_ctrl #(.PRID(PRID), .SR_RESET(SR_RESET)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic model_req();
        logic ir, er;
        ir = (|(bus.hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
        er = (bus.exc_code_in != 5'd0) && !m_sr[1];
        return !reset && (ir || er);
    endfunction

    function automatic logic [31:0] model_dout(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clock();
        logic ir, er;
        logic [31:0] old;
        if (reset) begin
            m_sr    = SR_RESET & SR_MASK;
            m_cause = 32'd0;
            m_epc   = 32'd0;
        end else begin
            ir  = (|(bus.hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
            er  = (bus.exc_code_in != 5'd0) && !m_sr[1];
            old = m_cause;
            m_cause = 32'd0;
            m_cause[15:10] = bus.hw_int;
            if (ir || er) begin
                m_sr[1]       = 1'b1;
                m_cause[31]   = bus.bd_in;
                m_cause[6:2]  = ir ? 5'd0 : bus.exc_code_in;
                m_epc         = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
            end else begin
                m_cause[31]  = old[31];
                m_cause[6:2] = old[6:2];
                if (bus.we && bus.addr == 5'd12) m_sr  = bus.din & SR_MASK;
                if (bus.we && bus.addr == 5'd14) m_epc = bus.din;
                if (bus.eret) m_sr[1] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.eret = 1'b0; bus.exc_code_in = 5'd0;
        bus.hw_int = 6'd0; bus.bd_in = 1'b0; bus.addr = 5'd0; bus.din = 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4];
        exp_rd = '{32'd0, 32'd0, 32'd0, PRID};
        reset = 1'b1;
        bus.hw_int = 6'h3F; bus.exc_code_in = 5'd9; bus.vpc = 32'hDEAD_BEEC;
        #1;
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_comb: got %b want 0", bus.req);
        end
        tick();
        tick();
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b want 0", bus.req);
        end
        n_checks++;
        if (bus.epc_out !== 32'd0) begin
            n_fail++; $display("FAIL reset_epc_out: got %h want 0", bus.epc_out);
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.addr = 5'(12 + i);
            #1;
            n_checks++;
            if (bus.dout !== exp_rd[i]) begin
                n_fail++; $display("FAIL reset_read_%0d: got %h want %h", 12 + i, bus.dout, exp_rd[i]);
            end
        end
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_req: got %b want 0", bus.req);
        end
    endtask

    task automatic test_interrupt();
        bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0000_0401;
        tick();
        bus.we = 1'b0;
        bus.hw_int = 6'b000001; bus.vpc = 32'h0000_3010; bus.bd_in = 1'b0;
        #1;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++; $display("FAIL int_req: got %b want 1", bus.req);
        end
        tick();
        n_checks++;
        if (bus.epc_out !== 32'h0000_3010) begin
            n_fail++; $display("FAIL int_epc: got %h want 00003010", bus.epc_out);
        end
        bus.addr = 5'd12; #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0403) begin
            n_fail++; $display("FAIL int_sr_exl: got %h want 00000403", bus.dout);
        end
        bus.addr = 5'd13; #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0400) begin
            n_fail++; $display("FAIL int_cause: got %h want 00000400", bus.dout);
        end
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++; $display("FAIL int_exl_blocks: got %b want 0", bus.req);
        end
    endtask

    task automatic test_eret();
        bus.eret = 1'b1;
        #1;
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++; $display("FAIL eret_cycle_req: got %b want 0", bus.req);
        end
        tick();
        bus.eret = 1'b0;
        bus.addr = 5'd12; #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0401) begin
            n_fail++; $display("FAIL eret_sr: got %h want 00000401", bus.dout);
        end
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++; $display("FAIL eret_reenter_req: got %b want 1", bus.req);
        end
        tick();
        bus.hw_int = 6'd0;
    endtask

    task automatic test_exception_bd();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        bus.hw_int = 6'b100000;
        bus.exc_code_in = 5'd4; bus.vpc = 32'h0000_3024; bus.bd_in = 1'b1;
        #1;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++; $display("FAIL exc_req: got %b want 1", bus.req);
        end
        tick();
        bus.exc_code_in = 5'd0; bus.bd_in = 1'b0;
        bus.addr = 5'd13; #1;
        n_checks++;
        if (bus.dout !== 32'h8000_8010) begin
            n_fail++; $display("FAIL exc_cause: got %h want 80008010", bus.dout);
        end
        n_checks++;
        if (bus.epc_out !== 32'h0000_3020) begin
            n_fail++; $display("FAIL exc_epc_bd: got %h want 00003020", bus.epc_out);
        end
        bus.hw_int = 6'd0;
    endtask

    task automatic test_priority();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        bus.hw_int = 6'b000001; bus.exc_code_in = 5'd10;
        bus.vpc = 32'h0000_5000; bus.bd_in = 1'b1;
        #1;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++; $display("FAIL prio_req: got %b want 1", bus.req);
        end
        tick();
        bus.addr = 5'd13; #1;
        n_checks++;
        if (bus.dout !== 32'h8000_0400) begin
            n_fail++; $display("FAIL prio_cause: got %h want 80000400", bus.dout);
        end
        n_checks++;
        if (bus.epc_out !== 32'h0000_4FFC) begin
            n_fail++; $display("FAIL prio_epc: got %h want 00004ffc", bus.epc_out);
        end
        idle();
    endtask

    task automatic test_mtc0();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        bus.exc_code_in = 5'd8; bus.vpc = 32'h0000_6000;
        bus.we = 1'b1; bus.addr = 5'd14; bus.din = 32'h0000_4000;
        tick();
        bus.exc_code_in = 5'd0; bus.we = 1'b0;
        n_checks++;
        if (bus.epc_out !== 32'h0000_6000) begin
            n_fail++; $display("FAIL mtc0_epc_dropped: got %h want 00006000", bus.epc_out);
        end
        bus.we = 1'b1; bus.addr = 5'd13; bus.din = 32'hFFFF_FFFF;
        tick();
        bus.we = 1'b0; #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0020) begin
            n_fail++; $display("FAIL mtc0_cause_ro: got %h want 00000020", bus.dout);
        end
        bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'hFFFF_FFFF; bus.eret = 1'b1;
        tick();
        bus.we = 1'b0; bus.eret = 1'b0; #1;
        n_checks++;
        if (bus.dout !== 32'h0000_FC01) begin
            n_fail++; $display("FAIL mtc0_sr_with_eret: got %h want 0000fc01", bus.dout);
        end
        bus.we = 1'b1; bus.addr = 5'd14; bus.din = 32'h1234_5678;
        tick();
        bus.we = 1'b0;
        n_checks++;
        if (bus.epc_out !== 32'h1234_5678) begin
            n_fail++; $display("FAIL mtc0_epc_write: got %h want 12345678", bus.epc_out);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.hw_int      = 6'($urandom);
            bus.exc_code_in = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.eret        = ($urandom_range(0, 4) == 0);
            bus.we          = ($urandom_range(0, 2) == 0);
            bus.addr        = 5'($urandom_range(10, 17));
            bus.din         = $urandom;
            bus.vpc         = $urandom;
            bus.bd_in       = 1'($urandom);
            #1;
            n_checks++;
            if (bus.req !== model_req()) begin
                n_fail++; $display("FAIL rand_req[%0d]: got %b want %b", i, bus.req, model_req());
            end
            n_checks++;
            if (bus.dout !== model_dout(bus.addr)) begin
                n_fail++; $display("FAIL rand_dout[%0d] addr %0d: got %h want %h", i, bus.addr, bus.dout, model_dout(bus.addr));
            end
            n_checks++;
            if (bus.epc_out !== m_epc) begin
                n_fail++; $display("FAIL rand_epc[%0d]: got %h want %h", i, bus.epc_out, m_epc);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        bus.vpc = 32'd0;
        idle();
        test_reset();
        test_interrupt();
        test_eret();
        test_exception_bd();
        test_priority();
        test_mtc0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
